load_data_unit: RTL

LOAD_DATA_UNIT -- requirements
Module: load_data_unit

---
 rtl/rv32_load_pkg.sv | 38 +++
 rtl/load_data_unit_align.sv | 37 +++
 rtl/load_data_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/rv32_load_pkg.sv
// Shared definitions for the RV32 load path: funct3 load-width codes,
// the load FSM state type and small decode helpers.
package rv32_load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    // Codes outside the five defined widths; these load as a full word.
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                 f3 == F3_LBU || f3 == F3_LHU);
    endfunction

    // Halfwords need ea[0]=0; words (and illegal codes, which act as words)
    // need ea[1:0]=0. Bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] ea_lo);
        logic half;
        half = (f3 == F3_LH) || (f3 == F3_LHU);
        if (half)
            return ea_lo[0];
        else if (f3 == F3_LB || f3 == F3_LBU)
            return 1'b0;
        else
            return (ea_lo != 2'b00);
    endfunction

endpackage

// File: rtl/load_data_unit_align.sv
// Combinational load alignment: selects byte/half from a little-endian
// memory word by the low address bits and sign- or zero-extends it.
module load_align
    import rv32_load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to the width.
    always_comb begin
        byte_sel = word[7:0];
        case (ea_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = ea_lo[1] ? word[31:16] : word[15:0];

        result = word;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_data_unit.sv
// RV32 load data unit: accepts a load request, issues one word-aligned
// memory read, waits for the read data and writes back the aligned,
// extended result.
// Optional feature: define LOAD_MISALIGN_TRAP_EN to trap misaligned
// halfword/word loads (and flag illegal funct3) on the fault output.
module load_data_unit
    import rv32_load_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [11:0] imm,
    input  logic [4:0]  rd_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault
);

    state_t      state;
    logic [31:0] ea_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic [31:0] ea_next;
    logic [31:0] aligned;
    logic        accept;
    logic        trap;

    // Effective address and handshake decode for the current request.
    always_comb begin
        ea_next = base + {{20{imm[11]}}, imm};
        accept  = req_valid && (state == IDLE);
`ifdef LOAD_MISALIGN_TRAP_EN
        trap    = accept && is_misaligned(funct3, ea_next[1:0]);
`else
        trap    = 1'b0;
`endif
    end

    load_align u_align (
        .word   (mem_rdata),
        .ea_lo  (ea_q[1:0]),
        .funct3 (f3_q),
        .result (aligned)
    );

    // Load FSM with latched request fields and captured read result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            ea_q   <= '0;
            f3_q   <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !trap) begin
                        ea_q  <= ea_next;
                        f3_q  <= funct3;
                        rd_q  <= rd_in;
                        state <= REQ;
                    end
                end
                REQ:  state <= WAIT;
                WAIT: begin
                    if (mem_rvalid) begin
                        data_q <= aligned;
                        state  <= WB;
                    end
                end
                WB:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    logic fault_q;

    // One-cycle fault pulse for a trapped misaligned or illegal-width load.
    always_ff @(posedge clk) begin
        if (!reset_n)
            fault_q <= 1'b0;
        else
            fault_q <= trap || (accept && is_illegal_f3(funct3));
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign mem_rd_en = (state == REQ);
    assign mem_addr  = (state == REQ) ? {ea_q[31:2], 2'b00} : '0;
    assign wb_valid  = (state == WB);
    assign wb_rd     = (state == WB) ? rd_q : '0;
    assign wb_data   = (state == WB) ? data_q : '0;

endmodule
